// File: rtl/rr_arb_mux2.sv
// rr_arb_mux2: two-source round-robin arbiter with burst limit feeding a
// registered 2:1 data mux. One output register stage on a valid/ready channel.
module rr_arb_mux2 #(
  parameter int WIDTH = 8,
  parameter int BURST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inA_valid,
  input  logic [WIDTH-1:0] inA,
  output logic             inA_ready,
  input  logic             inB_valid,
  input  logic [WIDTH-1:0] inB,
  output logic             inB_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_src,
  input  logic             out_ready
);
  localparam int CW = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST);
  localparam logic [CW-1:0] CONE = CW'(1);

  // Held output beat
  typedef struct packed {
    logic             vld;
    logic             src;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t         held;
  logic          owner;
  logic [CW-1:0] cnt;
  logic          g;
  logic          load_en;
  logic          any_v;
  logic          take;

  // Grant select: contention honours owner until its burst is used up;
  // a lone requester always wins regardless of the burst count.
  always_comb begin
    g = owner;
    if (inA_valid && inB_valid) g = (cnt < CMAX) ? owner : ~owner;
    else if (inA_valid)         g = 1'b0;
    else if (inB_valid)         g = 1'b1;
  end

  assign load_en   = ~held.vld | out_ready;
  assign any_v     = inA_valid | inB_valid;
  // Readys are forced low while reset is held so nothing is consumed.
  assign take      = load_en & any_v & ~reset;
  assign inA_ready = take & ~g & inA_valid;
  assign inB_ready = take &  g & inB_valid;
  assign sel       = g;

  assign out_valid = held.vld;
  assign out       = held.data;
  assign out_src   = held.src;

  // Output register plus owner/burst-count tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held  <= '0;
      owner <= 1'b0;
      cnt   <= '0;
    end else if (load_en) begin
      if (any_v) begin
        held.vld  <= 1'b1;
        held.src  <= g;
        held.data <= g ? inB : inA;
        if (g == owner) begin
          if (cnt != CMAX) cnt <= cnt + CONE;
        end else begin
          owner <= g;
          cnt   <= CONE;
        end
      end else begin
        // Drained with nothing new: data/src keep their last value.
        held.vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_mux2.sv
// tb_rr_arb_mux2: two DUTs (BURST=1 and BURST=3) share stimulus; a
// per-cycle model checks every output, with literal checks pinning the model.
module tb_rr_arb_mux2;
  logic       clk = 1'b0;
  logic       reset;
  logic       a_v, b_v, o_rdy;
  logic [7:0] a_d, b_d;
  logic [1:0] a_rdy, b_rdy, sel, ovld, osrc;
  logic [7:0] odat [2];

  int errors = 0;
  int checks = 0;
  int lg [2][$];

  // model state per instance
  int bur [2] = '{1, 3};
  bit mv [2], ms [2], mown [2];
  int mo [2], mrun [2];

  always #5 clk = ~clk;

  rr_arb_mux2 #(.WIDTH(8), .BURST(1)) u0 (
    .clk(clk), .reset(reset),
    .inA_valid(a_v), .inA(a_d), .inA_ready(a_rdy[0]),
    .inB_valid(b_v), .inB(b_d), .inB_ready(b_rdy[0]),
    .sel(sel[0]), .out_valid(ovld[0]), .out(odat[0]), .out_src(osrc[0]),
    .out_ready(o_rdy));

  rr_arb_mux2 #(.WIDTH(8), .BURST(3)) u1 (
    .clk(clk), .reset(reset),
    .inA_valid(a_v), .inA(a_d), .inA_ready(a_rdy[1]),
    .inB_valid(b_v), .inB(b_d), .inB_ready(b_rdy[1]),
    .sel(sel[1]), .out_valid(ovld[1]), .out(odat[1]), .out_src(osrc[1]),
    .out_ready(o_rdy));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  function automatic int packlog(input int i);
    int v = 0;
    for (int k = 0; k < lg[i].size(); k++) v |= lg[i][k] << k;
    return v;
  endfunction

  // Compare DUT outputs against the model mid-cycle, then advance the model
  // to what the coming rising edge must produce.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit eg, le, tk;
      if (reset) begin
        mv[i] = 0; ms[i] = 0; mo[i] = 0; mown[i] = 0; mrun[i] = 0;
      end
      if (a_v && b_v) eg = (mrun[i] < bur[i]) ? mown[i] : !mown[i];
      else if (a_v)   eg = 0;
      else if (b_v)   eg = 1;
      else            eg = mown[i];
      le = !mv[i] || o_rdy;
      tk = le && (a_v || b_v) && !reset;
      chk($sformatf("u%0d.sel", i), sel[i], eg);
      chk($sformatf("u%0d.inA_ready", i), a_rdy[i], tk && !eg && a_v);
      chk($sformatf("u%0d.inB_ready", i), b_rdy[i], tk && eg && b_v);
      chk($sformatf("u%0d.out_valid", i), ovld[i], mv[i]);
      chk($sformatf("u%0d.out", i), odat[i], mo[i]);
      chk($sformatf("u%0d.out_src", i), osrc[i], ms[i]);
      if (a_rdy[i]) lg[i].push_back(0);
      if (b_rdy[i]) lg[i].push_back(1);
      if (!reset && le) begin
        if (tk) begin
          mv[i] = 1; ms[i] = eg; mo[i] = eg ? b_d : a_d;
          if (eg == mown[i]) mrun[i] = (mrun[i] + 1 > bur[i]) ? bur[i] : mrun[i] + 1;
          else begin mown[i] = eg; mrun[i] = 1; end
        end else mv[i] = 0;
      end
    end
  end

  initial begin
    reset = 1; a_v = 0; b_v = 0; a_d = 0; b_d = 0; o_rdy = 1;
    step; step;
    chk("rst.out_valid", ovld, 2'b00);
    reset = 0;
    step;

    // A only: 11,22,33 each visible one cycle after accept, B never ready
    lg[0].delete(); lg[1].delete();
    a_v = 1; a_d = 8'h11;
    step; chk("aonly.out1", odat[0], 8'h11); chk("aonly.src1", osrc, 2'b00); a_d = 8'h22;
    step; chk("aonly.out2", odat[1], 8'h22); a_d = 8'h33;
    step; chk("aonly.out3", odat[0], 8'h33); chk("aonly.out3b", odat[1], 8'h33); a_v = 0;
    step; chk("aonly.drain", ovld, 2'b00); chk("aonly.held", odat[0], 8'h33);
    chk("aonly.log0", packlog(0), 0); chk("aonly.len0", lg[0].size(), 3);
    chk("aonly.log1", packlog(1), 0);

    // Contention from fresh reset: BURST=1 alternates, BURST=3 goes AAABBB
    reset = 1; step; reset = 0; step;
    lg[0].delete(); lg[1].delete();
    a_v = 1; b_v = 1;
    for (int k = 0; k < 6; k++) begin
      a_d = 8'h40 + 8'(k); b_d = 8'h80 + 8'(k);
      step;
    end
    chk("rr.b1.seq", packlog(0), 6'b101010); chk("rr.b1.len", lg[0].size(), 6);
    chk("rr.b3.seq", packlog(1), 6'b111000); chk("rr.b3.len", lg[1].size(), 6);
    chk("rr.b1.lastsrc", osrc[0], 1); chk("rr.b3.lastsrc", osrc[1], 1);

    // Async reset while a beat is held: clears before any clock edge
    chk("arst.pre", ovld, 2'b11);
    reset = 1; #1;
    chk("arst.out_valid", ovld, 2'b00);
    chk("arst.out0", odat[0], 0); chk("arst.out1", odat[1], 0);
    chk("arst.src", osrc, 2'b00);
    chk("arst.rdy", {a_rdy, b_rdy}, 4'b0);
    a_v = 0; b_v = 0;
    step; reset = 0; step;

    // Backpressure: A5 held, no readys, then release loads in same cycle
    a_v = 1; a_d = 8'hA5;
    step; chk("bp.load", odat[0], 8'hA5);
    o_rdy = 0; a_d = 8'h5A; b_v = 1; b_d = 8'hC3; #1;
    chk("bp.rdy", {a_rdy, b_rdy}, 4'b0); chk("bp.hold", odat[1], 8'hA5);
    step;
    chk("bp.rdy2", {a_rdy, b_rdy}, 4'b0); chk("bp.hold2", odat[0], 8'hA5);
    chk("bp.vld", ovld, 2'b11);
    o_rdy = 1; #1;
    chk("bp.release0", b_rdy[0], 1); chk("bp.release1", a_rdy[1], 1);
    step;
    chk("bp.next0", odat[0], 8'hC3); chk("bp.next1", odat[1], 8'h5A);
    a_v = 0; b_v = 0;
    step;

    // B alone after an A burst that exhausted the count
    reset = 1; step; reset = 0; step;
    a_v = 1; b_v = 0; a_d = 8'h21;
    step; step; step;
    a_v = 0; b_v = 1; b_d = 8'h9B;
    step;
    chk("bonly.src", osrc, 2'b11); chk("bonly.out", odat[1], 8'h9B);
    // owner=B cnt=1 now: BURST=1 must hand back to A, BURST=3 stays on B
    a_v = 1; a_d = 8'h66; b_d = 8'h77; #1;
    chk("bonly.sel", sel, 2'b10);
    step;
    chk("bonly.next0", odat[0], 8'h66); chk("bonly.next1", odat[1], 8'h77);
    a_v = 0; b_v = 0;
    step; step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
